usb_rx_buf_ctrl: RTL

Sequences the USB RX datapath output into a packet buffer and hands it to the host-side reader.
- Captures each byte strobed by store_rx_packet_data into a DEPTH-entry FIFO.
- Latches the decoded packet type and completion or error status.
- Arbitrates simultaneous RX writes and host reads on the shared storage.
- Sits between the RX top level and the AHB-facing slave logic.

---
 rtl/usb_rx_pkg.sv | 22 ++
 rtl/usb_rx_buf_ctrl_if.sv | 39 +++
 rtl/usb_rx_buf_mem.sv | 57 +++++
 rtl/usb_rx_buf_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB RX packet buffer and the RX decoder.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE,
    ERR
  } rx_buf_state_t;

  localparam int RX_BUF_DEPTH_DEF = 64;

  localparam logic [2:0] RX_PKT_NONE  = 3'd0;
  localparam logic [2:0] RX_PKT_OUT   = 3'd1;
  localparam logic [2:0] RX_PKT_IN    = 3'd2;
  localparam logic [2:0] RX_PKT_SETUP = 3'd3;
  localparam logic [2:0] RX_PKT_DATA0 = 3'd4;
  localparam logic [2:0] RX_PKT_DATA1 = 3'd5;
  localparam logic [2:0] RX_PKT_ACK   = 3'd6;
  localparam logic [2:0] RX_PKT_NAK   = 3'd7;

endpackage

// File: rtl/usb_rx_buf_ctrl_if.sv
// RX-side strobes plus host-side read/status signals of the USB RX packet buffer.
interface usb_rx_buf_ctrl_if #(
  parameter int DEPTH = usb_rx_pkg::RX_BUF_DEPTH_DEF
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rx_transfer_active;
  logic             store_rx_packet_data;
  logic [7:0]       rx_packet_data;
  logic [2:0]       rx_packet;
  logic             rx_data_ready;
  logic             rx_error;
  logic             flush;
  logic             get_rx_data;
  logic             host_clear;
  logic [7:0]       rd_data;
  logic [CNT_W-1:0] buffer_occupancy;
  logic             rx_pkt_valid;
  logic [2:0]       rx_pkt_type;
  logic             rx_err_flag;
  logic             overflow;
  logic             rx_busy;
  logic [7:0]       rx_pkt_count;

  modport slave (
    input  rx_transfer_active, store_rx_packet_data, rx_packet_data, rx_packet,
           rx_data_ready, rx_error, flush, get_rx_data, host_clear,
    output rd_data, buffer_occupancy, rx_pkt_valid, rx_pkt_type, rx_err_flag,
           overflow, rx_busy, rx_pkt_count
  );

  modport master (
    output rx_transfer_active, store_rx_packet_data, rx_packet_data, rx_packet,
           rx_data_ready, rx_error, flush, get_rx_data, host_clear,
    input  rd_data, buffer_occupancy, rx_pkt_valid, rx_pkt_type, rx_err_flag,
           overflow, rx_busy, rx_pkt_count
  );

endinterface

// File: rtl/usb_rx_buf_mem.sv
// DEPTH x 8 byte FIFO storage with wrapping pointers, occupancy count and show-ahead head byte.
module usb_rx_buf_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic [CNT_W-1:0] count
);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Callers pre-qualify wr_en/rd_en against full/empty; clr overrides both.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wptr_q] <= wdata;
  end

  assign rdata = (count_q == '0) ? 8'h00 : mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/usb_rx_buf_ctrl.sv
// USB RX packet buffer controller: FSM, status flags and RX-write / host-read arbitration.
// Optional good-packet counter enabled by defining USB_RX_PKT_COUNT_EN.
module usb_rx_buf_ctrl
  import usb_rx_pkg::*;
#(
  parameter int DEPTH  = RX_BUF_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_rx_buf_ctrl_if.slave   bus
);

  rx_buf_state_t    state_q, state_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [2:0]       type_q, type_d;
  logic             act_q;
  logic             wr_en, rd_en, clr, full, empty, act_rise, ovf_set;
  logic [CNT_W-1:0] count;
  logic [7:0]       rdata;

  usb_rx_buf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_mem (
    .clk   (clk),
    .n_rst (n_rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .clr   (clr),
    .wdata (bus.rx_packet_data),
    .rdata (rdata),
    .count (count)
  );

  // A pop frees the slot on the same edge, so a write is allowed at full when popping.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    act_rise = bus.rx_transfer_active & ~act_q;
    rd_en    = bus.get_rx_data & ~empty;
    wr_en    = (state_q == ACTIVE) & bus.store_rx_packet_data & (~full | rd_en);
    clr      = bus.flush | bus.host_clear | ((state_q == ACTIVE) & bus.rx_error);
    ovf_set  = (state_q == ACTIVE) & bus.store_rx_packet_data & full & ~rd_en & ~clr;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    type_d  = type_q;
    if (bus.host_clear) begin
      state_d = IDLE;
      valid_d = 1'b0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.rx_transfer_active) begin
          state_d = ACTIVE;
          valid_d = 1'b0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
        ACTIVE: begin
          if (ovf_set) ovf_d = 1'b1;
          if (bus.rx_error) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (bus.rx_data_ready) begin
            state_d = DONE;
            type_d  = bus.rx_packet;
            valid_d = 1'b1;
          end
        end
        DONE: begin
          if (bus.rx_transfer_active) begin
            state_d = ACTIVE;
            valid_d = 1'b0;
          end else if (empty) begin
            state_d = IDLE;
          end
        end
        ERR: if (act_rise) begin
          state_d = ACTIVE;
          valid_d = 1'b0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      type_q  <= '0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      type_q  <= type_d;
      act_q   <= bus.rx_transfer_active;
    end
  end

`ifdef USB_RX_PKT_COUNT_EN
  logic [7:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if ((state_q == ACTIVE) && (state_d == DONE) && (pkt_cnt_q != 8'hFF))
      pkt_cnt_d = pkt_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign bus.rx_pkt_count = pkt_cnt_q;
`else
  assign bus.rx_pkt_count = 8'h00;
`endif

  assign bus.rd_data          = rdata;
  assign bus.buffer_occupancy = count;
  assign bus.rx_pkt_valid     = valid_q;
  assign bus.rx_pkt_type      = type_q;
  assign bus.rx_err_flag      = err_q;
  assign bus.overflow         = ovf_q;
  assign bus.rx_busy          = busy_q;

endmodule
